// File: rtl/imgproc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imgproc_pkg
// Purpose  : State encoding, pixel width and width helper for the frame sequencer.
// Revision : 1.0
// ============================================================================
package imgproc_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACTIVE = 3'd1,
        S_HBLANK = 3'd2,
        S_FLUSH  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imgproc_out_counter.sv
`default_nettype none
// ============================================================================
// Module   : imgproc_out_counter
// Purpose  : Saturating output-pixel counter with a sticky overrun flag.
// Revision : 1.0
// ============================================================================
module imgproc_out_counter
    import imgproc_pkg::*;
#(
    parameter int MAX_COUNT = 12,
    parameter int CNT_W     = clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic             overrun_o
);

    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovr_q;
    logic             ovr_d;

    always_comb begin
        cnt_d = cnt_q;
        ovr_d = ovr_q;
        if (clr_i) begin
            cnt_d = '0;
            ovr_d = 1'b0;
        end else if (inc_i) begin
            if (cnt_q == C_MAX) begin
                ovr_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovr_q <= ovr_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;
    assign overrun_o  = ovr_q;

endmodule
`default_nettype wire

// File: rtl/imgproc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imgproc_frame_ctrl
// Purpose  : Forwards one frame into the grey/Sobel pipeline with line blanking,
//            drains it with zero pixels and reports completion or timeout.
// Revision : 1.0
// ============================================================================
module imgproc_frame_ctrl
    import imgproc_pkg::*;
#(
    parameter int   IMG_WIDTH    = 640,
    parameter int   IMG_HEIGHT   = 480,
    parameter int   HBLANK       = 4,
    parameter int   OUT_PIXELS   = 307200,
    parameter int   FLUSH_PIXELS = 1282,
    localparam int  CNT_W        = clog2(OUT_PIXELS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [PIX_W-1:0] s_r_i,
    input  logic [PIX_W-1:0] s_g_i,
    input  logic [PIX_W-1:0] s_b_i,
    output logic             pipe_valid_o,
    output logic [PIX_W-1:0] pipe_r_o,
    output logic [PIX_W-1:0] pipe_g_o,
    output logic [PIX_W-1:0] pipe_b_o,
    input  logic             pipe_out_valid_i,
    output logic             busy_o,
    output logic             frame_done_o,
    output logic             err_timeout_o,
    output logic             err_overrun_o,
    output logic [CNT_W-1:0] out_cnt_o
);

    localparam int C_X_W  = clog2(IMG_WIDTH);
    localparam int C_Y_W  = clog2(IMG_HEIGHT);
    localparam int C_F_W  = clog2(FLUSH_PIXELS);
    localparam int C_HB_W = clog2(HBLANK + 1);

    localparam logic [C_X_W-1:0]  C_X_LAST  = C_X_W'(IMG_WIDTH - 1);
    localparam logic [C_Y_W-1:0]  C_Y_LAST  = C_Y_W'(IMG_HEIGHT - 1);
    localparam logic [C_F_W-1:0]  C_F_LAST  = C_F_W'(FLUSH_PIXELS - 1);
    localparam logic [C_HB_W-1:0] C_HB_LAST = C_HB_W'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam logic [CNT_W-1:0]  C_OUT_MAX = CNT_W'(OUT_PIXELS);

    state_t                 state_q, state_d;
    logic [C_X_W-1:0]       x_q, x_d;
    logic [C_Y_W-1:0]       y_q, y_d;
    logic [C_HB_W-1:0]      hb_q, hb_d;
    logic [C_F_W-1:0]       flush_q, flush_d;
    logic                   pv_q, pv_d;
    logic [3*PIX_W-1:0]     rgb_q, rgb_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tout_q, tout_d;
    logic                   cnt_clr;
    logic                   cnt_inc;
    logic                   reached;
    logic                   limit;
    logic [CNT_W-1:0]       cnt_next;

    assign s_ready_o = (state_q == S_ACTIVE);
    assign cnt_inc   = pipe_out_valid_i && (state_q != S_IDLE);
    // An output arriving in the same cycle already counts toward completion.
    assign reached   = (cnt_next == C_OUT_MAX);
    assign limit     = (flush_q == C_F_LAST);

    imgproc_out_counter #(
        .MAX_COUNT (OUT_PIXELS),
        .CNT_W     (CNT_W)
    ) u_out_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (cnt_clr),
        .inc_i      (cnt_inc),
        .cnt_o      (out_cnt_o),
        .cnt_next_o (cnt_next),
        .overrun_o  (err_overrun_o)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        hb_d    = hb_q;
        flush_d = flush_q;
        pv_d    = 1'b0;
        rgb_d   = rgb_q;
        tout_d  = tout_q;
        cnt_clr = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    x_d     = '0;
                    y_d     = '0;
                    hb_d    = '0;
                    flush_d = '0;
                    tout_d  = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (s_valid_i) begin
                    pv_d  = 1'b1;
                    rgb_d = {s_r_i, s_g_i, s_b_i};
                    if (x_q == C_X_LAST) begin
                        x_d = '0;
                        if (y_q == C_Y_LAST) begin
                            flush_d = '0;
                            state_d = S_FLUSH;
                        end else begin
                            y_d = y_q + 1'b1;
                            if (HBLANK > 0) begin
                                hb_d    = '0;
                                state_d = S_HBLANK;
                            end
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            S_HBLANK: begin
                if (hb_q == C_HB_LAST) begin
                    state_d = S_ACTIVE;
                end else begin
                    hb_d = hb_q + 1'b1;
                end
            end
            S_FLUSH: begin
                pv_d    = 1'b1;
                rgb_d   = '0;
                flush_d = flush_q + 1'b1;
                if (reached || limit) begin
                    state_d = S_DONE;
                    tout_d  = !reached;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over every transition but leaves flags and counts intact.
        if (abort_i) begin
            state_d = S_IDLE;
            pv_d    = 1'b0;
            rgb_d   = rgb_q;
            tout_d  = tout_q;
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            hb_q    <= '0;
            flush_q <= '0;
            pv_q    <= 1'b0;
            rgb_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hb_q    <= hb_d;
            flush_q <= flush_d;
            pv_q    <= pv_d;
            rgb_q   <= rgb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
        end
    end

    assign pipe_valid_o  = pv_q;
    assign pipe_r_o      = rgb_q[3*PIX_W-1:2*PIX_W];
    assign pipe_g_o      = rgb_q[2*PIX_W-1:PIX_W];
    assign pipe_b_o      = rgb_q[PIX_W-1:0];
    assign busy_o        = busy_q;
    assign frame_done_o  = done_q;
    assign err_timeout_o = tout_q;

endmodule
`default_nettype wire

// File: tb/tb_imgproc_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imgproc_frame_ctrl
// Purpose  : Self-checking bench for imgproc_frame_ctrl against a frame-level model.
// Revision : 1.0
// ============================================================================
module tb_imgproc_frame_ctrl;

    localparam int W     = 4;
    localparam int H     = 3;
    localparam int HB    = 2;
    localparam int OUTP  = 12;
    localparam int FLP   = 10;
    localparam int N_PIX = W * H;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_r, s_g, s_b;
    logic       pipe_valid;
    logic [7:0] pipe_r, pipe_g, pipe_b;
    logic       pipe_out_valid;
    logic       busy;
    logic       frame_done;
    logic       err_timeout;
    logic       err_overrun;
    logic [3:0] out_cnt;

    imgproc_frame_ctrl #(
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H),
        .HBLANK       (HB),
        .OUT_PIXELS   (OUTP),
        .FLUSH_PIXELS (FLP)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (start),
        .abort_i          (abort),
        .s_valid_i        (s_valid),
        .s_ready_o        (s_ready),
        .s_r_i            (s_r),
        .s_g_i            (s_g),
        .s_b_i            (s_b),
        .pipe_valid_o     (pipe_valid),
        .pipe_r_o         (pipe_r),
        .pipe_g_o         (pipe_g),
        .pipe_b_o         (pipe_b),
        .pipe_out_valid_i (pipe_out_valid),
        .busy_o           (busy),
        .frame_done_o     (frame_done),
        .err_timeout_o    (err_timeout),
        .err_overrun_o    (err_overrun),
        .out_cnt_o        (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    // Frame-level reference: pixels accepted so far, blank cycles still owed,
    // drain cycles spent, returned-output count and the sticky error flags.
    bit          m_run, m_done, m_terr, m_oerr;
    int          m_nacc, m_blank, m_fk, m_cnt;
    logic [23:0] m_rgb;
    int          ov_sent, n_pv, n_fd;
    bit          tgl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_terr = 0; m_oerr = 0;
        m_nacc = 0; m_blank = 0; m_fk = 0; m_cnt = 0;
        m_rgb = '0;
    endtask

    task automatic cyc(input bit v, input bit ov, input bit st, input bit ab);
        logic [23:0] pix;
        bit e_pv, e_fd;
        pix = 24'($urandom);
        s_valid = v; s_r = pix[23:16]; s_g = pix[15:8]; s_b = pix[7:0];
        pipe_out_valid = ov; start = st; abort = ab;
        if (ov) ov_sent++;
        #1;
        chk("s_ready", 32'(s_ready), 32'(m_run && !m_done && m_nacc < N_PIX && m_blank == 0));
        e_pv = 0; e_fd = 0;
        if (!m_run) begin
            if (st && !ab) begin
                m_run = 1; m_done = 0; m_nacc = 0; m_blank = 0; m_fk = 0;
                m_cnt = 0; m_terr = 0; m_oerr = 0;
            end
        end else begin
            if (ov) begin
                if (m_cnt == OUTP) m_oerr = 1;
                else m_cnt++;
            end
            if (ab) begin
                m_run = 0; m_done = 0;
            end else if (m_done) begin
                m_run = 0; m_done = 0;
            end else if (m_nacc < N_PIX) begin
                if (m_blank > 0) m_blank--;
                else if (v) begin
                    e_pv = 1; m_rgb = pix; m_nacc++;
                    if (m_nacc % W == 0 && m_nacc < N_PIX) m_blank = HB;
                end
            end else begin
                e_pv = 1; m_rgb = '0;
                if (m_cnt == OUTP || m_fk == FLP - 1) begin
                    m_done = 1; e_fd = 1;
                    if (m_cnt < OUTP) m_terr = 1;
                end
                m_fk++;
            end
        end
        @(posedge clk);
        #1;
        if (pipe_valid === 1'b1) n_pv++;
        if (frame_done === 1'b1) n_fd++;
        chk("pipe_valid", 32'(pipe_valid), 32'(e_pv));
        chk("pipe_rgb", 32'({pipe_r, pipe_g, pipe_b}), 32'(m_rgb));
        chk("frame_done", 32'(frame_done), 32'(e_fd));
        chk("busy", 32'(busy), 32'(m_run));
        chk("out_cnt", 32'(out_cnt), 32'(m_cnt));
        chk("err_timeout", 32'(err_timeout), 32'(m_terr));
        chk("err_overrun", 32'(err_overrun), 32'(m_oerr));
    endtask

    // mode 0: s_valid held high, 1: toggling, 2: random.
    task automatic frame_step(input int mode, input int n_out, input bit gaps, input bit st);
        bit v, ov;
        if (mode == 0) v = 1'b1;
        else if (mode == 1) begin v = tgl; tgl = ~tgl; end
        else v = 1'($urandom);
        if (m_nacc < N_PIX) ov = (ov_sent < n_out - 8);
        else ov = (ov_sent < n_out) && (!gaps || $urandom_range(3) != 0);
        cyc(v, ov, st, 1'b0);
    endtask

    task automatic begin_frame();
        ov_sent = 0; n_pv = 0; n_fd = 0; tgl = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic run_frame(input int mode, input int n_out, input bit gaps);
        begin_frame();
        for (int i = 0; i < 200 && m_run; i++) frame_step(mode, n_out, gaps, 1'b0);
        chk("frame_bound", 32'(m_run), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 0; abort = 0; s_valid = 0; pipe_out_valid = 0;
        s_r = 0; s_g = 0; s_b = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_pipe_valid", 32'(pipe_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        chk("rst_errs", 32'({err_timeout, err_overrun, frame_done}), 32'd0);
        rst_n = 1'b1;

        // Nominal frame, all outputs returned.
        run_frame(0, 12, 1'b0);
        chk("t1_done_pulses", 32'(n_fd), 32'd1);
        chk("t1_pv_count", 32'(n_pv), 32'd20);
        chk("t1_out_cnt", 32'(out_cnt), 32'd12);
        chk("t1_errs", 32'({err_timeout, err_overrun}), 32'd0);

        // Upstream gaps.
        run_frame(1, 12, 1'b0);
        chk("t2_done_pulses", 32'(n_fd), 32'd1);
        chk("t2_out_cnt", 32'(out_cnt), 32'd12);

        // Short return -> timeout after the full drain.
        run_frame(0, 9, 1'b0);
        chk("t3_pv_count", 32'(n_pv), 32'd22);
        chk("t3_out_cnt", 32'(out_cnt), 32'd9);
        chk("t3_timeout", 32'(err_timeout), 32'd1);
        chk("t3_done_pulses", 32'(n_fd), 32'd1);

        // One output too many -> overrun.
        run_frame(0, 13, 1'b0);
        chk("t4_out_cnt", 32'(out_cnt), 32'd12);
        chk("t4_overrun", 32'(err_overrun), 32'd1);
        chk("t4_timeout", 32'(err_timeout), 32'd0);

        // Abort during the blank after line 2, then a clean frame.
        begin_frame();
        for (int i = 0; i < 100 && !(m_nacc == 2 * W && m_blank == HB); i++)
            frame_step(0, 12, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_pipe_valid", 32'(pipe_valid), 32'd0);
        chk("t5_done_pulses", 32'(n_fd), 32'd0);
        run_frame(0, 12, 1'b0);
        chk("t5_clean_done", 32'(n_fd), 32'd1);
        chk("t5_clean_cnt", 32'(out_cnt), 32'd12);

        // start held while busy, then asynchronous reset in the drain phase.
        begin_frame();
        for (int i = 0; i < 100 && !(m_nacc == N_PIX && m_fk == 3); i++)
            frame_step(0, 12, 1'b0, 1'b1);
        chk("t6_in_flush", 32'(m_fk), 32'd3);
        s_valid = 0; start = 0; pipe_out_valid = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_pv", 32'(pipe_valid), 32'd0);
        chk("t6_async_busy", 32'(busy), 32'd0);
        chk("t6_async_cnt", 32'(out_cnt), 32'd0);
        chk("t6_async_rgb", 32'({pipe_r, pipe_g, pipe_b}), 32'd0);
        chk("t6_async_flags", 32'({frame_done, err_timeout, err_overrun, s_ready}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // Randomised frames: random valid, random output count and return gaps.
        for (int k = 0; k < 4; k++) run_frame(2, 9 + $urandom_range(4), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
